// File: rtl/rc4_phase_sequencer.sv
// RC4 key-search phase sequencer: walks each candidate key through the
// init, shuffle, decrypt and check engines and grants the shared S-memory
// port to whichever engine owns the current phase.
module rc4_phase_sequencer #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        abort,

    output logic        init_start,
    output logic        shfl_start,
    output logic        deco_start,
    output logic        chk_start,

    input  logic        init_done,
    input  logic        shfl_done,
    input  logic        deco_done,
    input  logic        chk_done,
    input  logic        chk_pass,

    input  logic [7:0]  init_addr,
    input  logic [7:0]  init_data,
    input  logic        init_wren,
    input  logic [7:0]  shfl_addr,
    input  logic [7:0]  shfl_data,
    input  logic        shfl_wren,
    input  logic [7:0]  deco_addr,
    input  logic [7:0]  deco_data,
    input  logic        deco_wren,

    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_wren,

    output logic [23:0] key,
    output logic        busy,
    output logic        found,
    output logic        not_found
);

    localparam int unsigned KEY_W = 24;
    localparam int unsigned MEM_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_SHFL    = 3'd2,
        S_DECO    = 3'd3,
        S_CHECK   = 3'd4,
        S_NEXT    = 3'd5,
        S_FOUND   = 3'd6,
        S_EXHAUST = 3'd7
    } state_e;

    state_e             state_q, state_d;
    logic               entry_q, entry_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               found_q, found_d;
    logic               not_found_q, not_found_d;

    // State, key and status registers; reset abandons any search in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            entry_q     <= 1'b0;
            key_q       <= KEY_START;
            found_q     <= 1'b0;
            not_found_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            key_q       <= key_d;
            found_q     <= found_d;
            not_found_q <= not_found_d;
        end
    end

    // Next-state logic; abort overrides go and every engine done pulse.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        found_d     = found_q;
        not_found_d = not_found_q;

        if (abort) begin
            state_d     = S_IDLE;
            found_d     = 1'b0;
            not_found_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_FOUND, S_EXHAUST: begin
                    if (go) begin
                        state_d     = S_INIT;
                        key_d       = KEY_START;
                        found_d     = 1'b0;
                        not_found_d = 1'b0;
                    end
                end
                S_INIT: begin
                    if (init_done) state_d = S_SHFL;
                end
                S_SHFL: begin
                    if (shfl_done) state_d = S_DECO;
                end
                S_DECO: begin
                    if (deco_done) state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (chk_done) begin
                        if (chk_pass) begin
                            state_d = S_FOUND;
                            found_d = 1'b1;
                        end else if (key_q == KEY_MAX) begin
                            state_d     = S_EXHAUST;
                            not_found_d = 1'b1;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    state_d = S_INIT;
                    key_d   = key_q + KEY_W'(1);
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Flags the first cycle spent in a newly entered state.
        entry_d = (state_d != state_q);
    end

    // Start pulses, S-memory grant and busy decoded from the registered state.
    always_comb begin
        init_start = 1'b0;
        shfl_start = 1'b0;
        deco_start = 1'b0;
        chk_start  = 1'b0;
        mem_addr   = MEM_W'(0);
        mem_data   = MEM_W'(0);
        mem_wren   = 1'b0;
        busy       = 1'b0;

        unique case (state_q)
            S_INIT: begin
                init_start = entry_q;
                mem_addr   = init_addr;
                mem_data   = init_data;
                mem_wren   = init_wren;
                busy       = 1'b1;
            end
            S_SHFL: begin
                shfl_start = entry_q;
                mem_addr   = shfl_addr;
                mem_data   = shfl_data;
                mem_wren   = shfl_wren;
                busy       = 1'b1;
            end
            S_DECO: begin
                deco_start = entry_q;
                mem_addr   = deco_addr;
                mem_data   = deco_data;
                mem_wren   = deco_wren;
                busy       = 1'b1;
            end
            S_CHECK: begin
                chk_start = entry_q;
                busy      = 1'b1;
            end
            S_NEXT: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase

        // An abort cycle must never launch an engine or write S-memory.
        if (abort) begin
            init_start = 1'b0;
            shfl_start = 1'b0;
            deco_start = 1'b0;
            chk_start  = 1'b0;
            mem_wren   = 1'b0;
        end
    end

    assign key       = key_q;
    assign found     = found_q;
    assign not_found = not_found_q;

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Directed bench for rc4_phase_sequencer: a cycle table for single-step
// behaviour plus engine-model sequences for full searches, abort and reset.
module tb_rc4_phase_sequencer;

    localparam logic [23:0] XS = 24'h3FFFFD;
    localparam logic [23:0] XM = 24'h3FFFFF;
    localparam int NV = 21;

    logic clk, rst_n;
    logic go, go_x, abort;
    logic init_done, shfl_done, deco_done, chk_done, chk_pass;
    logic [7:0] init_addr, init_data, shfl_addr, shfl_data, deco_addr, deco_data;
    logic init_wren, shfl_wren, deco_wren;

    logic init_start, shfl_start, deco_start, chk_start;
    logic [7:0] mem_addr, mem_data;
    logic mem_wren;
    logic [23:0] key;
    logic busy, found, not_found;

    logic x_init_start, x_shfl_start, x_deco_start, x_chk_start;
    logic [7:0] x_mem_addr, x_mem_data;
    logic x_mem_wren;
    logic [23:0] x_key;
    logic x_busy, x_found, x_not_found;

    int checks, errors;
    int cyc;
    int t_i, t_s, t_d, t_c;
    int n_i, n_s, n_d, n_c;
    int attempt, pass_at, last_fail;
    logic sel_x;
    logic [23:0] kstart;

    logic s_init, s_shfl, s_deco, s_chk, f_sel, nf_sel;
    logic [23:0] key_sel;
    assign s_init  = sel_x ? x_init_start : init_start;
    assign s_shfl  = sel_x ? x_shfl_start : shfl_start;
    assign s_deco  = sel_x ? x_deco_start : deco_start;
    assign s_chk   = sel_x ? x_chk_start  : chk_start;
    assign f_sel   = sel_x ? x_found      : found;
    assign nf_sel  = sel_x ? x_not_found  : not_found;
    assign key_sel = sel_x ? x_key        : key;

    rc4_phase_sequencer dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
        .init_start(init_start), .shfl_start(shfl_start),
        .deco_start(deco_start), .chk_start(chk_start),
        .init_done(init_done), .shfl_done(shfl_done),
        .deco_done(deco_done), .chk_done(chk_done), .chk_pass(chk_pass),
        .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
        .shfl_addr(shfl_addr), .shfl_data(shfl_data), .shfl_wren(shfl_wren),
        .deco_addr(deco_addr), .deco_data(deco_data), .deco_wren(deco_wren),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .key(key), .busy(busy), .found(found), .not_found(not_found)
    );

    rc4_phase_sequencer #(.KEY_START(XS), .KEY_MAX(XM)) dut_x (
        .clk(clk), .rst_n(rst_n), .go(go_x), .abort(abort),
        .init_start(x_init_start), .shfl_start(x_shfl_start),
        .deco_start(x_deco_start), .chk_start(x_chk_start),
        .init_done(init_done), .shfl_done(shfl_done),
        .deco_done(deco_done), .chk_done(chk_done), .chk_pass(chk_pass),
        .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
        .shfl_addr(shfl_addr), .shfl_data(shfl_data), .shfl_wren(shfl_wren),
        .deco_addr(deco_addr), .deco_data(deco_data), .deco_wren(deco_wren),
        .mem_addr(x_mem_addr), .mem_data(x_mem_data), .mem_wren(x_mem_wren),
        .key(x_key), .busy(x_busy), .found(x_found), .not_found(x_not_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ins  = {go, abort, init_done, shfl_done, deco_done, chk_done, chk_pass}
    // outs = {busy, init_start, shfl_start, deco_start, chk_start, found, not_found}
    typedef struct packed {
        logic [6:0]  ins;
        logic [6:0]  outs;
        logic [23:0] key;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(input logic [6:0] i, input logic [6:0] o, input logic [23:0] k);
        vec_t v;
        v.ins  = i;
        v.outs = o;
        v.key  = k;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and drop every one-cycle pulse input.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        go = 1'b0; go_x = 1'b0; abort = 1'b0;
        init_done = 1'b0; shfl_done = 1'b0; deco_done = 1'b0;
        chk_done = 1'b0; chk_pass = 1'b0;
    endtask

    task automatic clear_engine();
        t_i = 0; t_s = 0; t_d = 0; t_c = 0;
        n_i = 0; n_s = 0; n_d = 0; n_c = 0;
        attempt = 0; last_fail = 0;
    endtask

    // Engine model: each engine answers done 5 cycles after its start.
    task automatic engine();
        if (t_i > 0) begin t_i--; if (t_i == 0) init_done = 1'b1; end
        if (t_s > 0) begin t_s--; if (t_s == 0) shfl_done = 1'b1; end
        if (t_d > 0) begin t_d--; if (t_d == 0) deco_done = 1'b1; end
        if (t_c > 0) begin
            t_c--;
            if (t_c == 0) begin
                chk_done = 1'b1;
                chk_pass = (attempt == pass_at);
                if (!chk_pass) last_fail = cyc;
                attempt++;
            end
        end
        if (s_init) begin
            if (n_i > 0) chk("next_len", 64'(cyc - last_fail), 64'd2);
            chk("attempt_key", 64'(key_sel), 64'(kstart + 24'(n_i)));
            n_i++; t_i = 5;
        end
        if (s_shfl) begin n_s++; t_s = 5; end
        if (s_deco) begin n_d++; t_d = 5; end
        if (s_chk)  begin n_c++; t_c = 5; end
    endtask

    // S-memory grant check against the phase the engine model believes is active.
    task automatic mux_check();
        if (t_i > 0 || init_done) begin
            chk("mux_init", {55'd0, mem_wren, mem_addr}, {55'd0, 1'b1, init_addr});
        end else if (t_s > 0 || shfl_done) begin
            chk("mux_shfl", {47'd0, mem_wren, mem_addr, mem_data}, {47'd0, 1'b0, shfl_addr, shfl_data});
        end else if (t_d > 0 || deco_done) begin
            chk("mux_deco", {47'd0, mem_wren, mem_addr, mem_data}, {47'd0, 1'b1, deco_addr, deco_data});
        end else begin
            chk("mux_idle", {47'd0, mem_wren, mem_addr, mem_data}, 64'd0);
        end
    endtask

    task automatic run_search(input logic x, input int pa, input logic mux, output logic ended);
        sel_x = x;
        kstart = x ? XS : 24'h0;
        pass_at = pa;
        clear_engine();
        ended = 1'b0;
        if (x) go_x = 1'b1; else go = 1'b1;
        for (int c = 0; c < 600 && !ended; c++) begin
            tick();
            engine();
            if (mux) begin
                init_addr = 8'($urandom); init_data = 8'($urandom);
                shfl_addr = 8'($urandom); shfl_data = 8'($urandom);
                deco_addr = 8'($urandom); deco_data = 8'($urandom);
                init_wren = 1'b1; shfl_wren = 1'b0; deco_wren = 1'b1;
            end
            #1;
            if (mux) mux_check();
            if (f_sel || nf_sel) ended = 1'b1;
        end
        init_wren = 1'b0; deco_wren = 1'b0; shfl_wren = 1'b0;
        if (!ended) chk("search_timeout", 64'd0, 64'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            engine();
        end
    endtask

    task automatic abort_test();
        logic hit;
        int extra;
        sel_x = 1'b0; kstart = 24'h0; pass_at = 0;
        clear_engine();
        hit = 1'b0;
        go = 1'b1;
        for (int c = 0; c < 200 && !hit; c++) begin
            tick();
            engine();
            if (shfl_done) begin
                shfl_wren = 1'b1; shfl_addr = 8'h77;
                abort = 1'b1;
                hit = 1'b1;
                #1;
                chk("abort_gate_wren", 64'(mem_wren), 64'd0);
                chk("abort_gate_starts", 64'({init_start, shfl_start, deco_start, chk_start}), 64'd0);
            end
        end
        if (!hit) chk("abort_reached", 64'd0, 64'd1);
        clear_engine();
        shfl_wren = 1'b0;
        tick();
        #1;
        chk("abort_idle", 64'({busy, found, not_found, mem_wren}), 64'd0);
        chk("abort_key", 64'(key), 64'd0);
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            #1;
            if (init_start || shfl_start || deco_start || chk_start) extra++;
        end
        chk("abort_no_resume", 64'(extra), 64'd0);
    endtask

    task automatic reset_test();
        logic hit;
        int extra;
        sel_x = 1'b0; kstart = 24'h0; pass_at = 99;
        clear_engine();
        hit = 1'b0;
        go = 1'b1;
        for (int c = 0; c < 300 && !hit; c++) begin
            tick();
            engine();
            if (n_d == 2 && t_d == 3) begin
                deco_wren = 1'b1; deco_addr = 8'h33; deco_data = 8'hC4;
                #1;
                chk("pre_reset_grant", {31'd0, mem_wren, mem_addr, key}, {31'd0, 1'b1, 8'h33, 24'h1});
                #1;
                rst_n = 1'b0;
                #1;
                chk("async_rst_outs", 64'({busy, init_start, shfl_start, deco_start, chk_start, found, not_found, mem_wren}), 64'd0);
                chk("async_rst_mem", 64'({mem_addr, mem_data}), 64'd0);
                chk("async_rst_key", 64'(key), 64'd0);
                hit = 1'b1;
            end
        end
        if (!hit) chk("reset_reached", 64'd0, 64'd1);
        clear_engine();
        deco_wren = 1'b0;
        tick();
        go = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            #1;
            if (init_start || shfl_start || deco_start || chk_start || busy) extra++;
        end
        chk("no_start_after_reset", 64'(extra), 64'd0);
        go = 1'b1;
        tick();
        #1;
        chk("restart_after_reset", 64'({init_start, busy, key}), 64'({1'b1, 1'b1, 24'h0}));
        abort = 1'b1;
        tick();
    endtask

    initial begin
        logic ended;
        logic [6:0] outs;

        checks = 0; errors = 0; cyc = 0;
        sel_x = 1'b0; kstart = 24'h0; pass_at = 0;
        clear_engine();
        go = 1'b0; go_x = 1'b0; abort = 1'b0;
        init_done = 1'b0; shfl_done = 1'b0; deco_done = 1'b0;
        chk_done = 1'b0; chk_pass = 1'b0;
        init_addr = 8'h0; init_data = 8'h0; init_wren = 1'b0;
        shfl_addr = 8'h0; shfl_data = 8'h0; shfl_wren = 1'b0;
        deco_addr = 8'h0; deco_data = 8'h0; deco_wren = 1'b0;

        tbl[0]  = mk(7'b0000000, 7'b0000000, 24'h0);
        tbl[1]  = mk(7'b1000000, 7'b0000000, 24'h0);
        tbl[2]  = mk(7'b0000000, 7'b1100000, 24'h0);
        tbl[3]  = mk(7'b0001000, 7'b1000000, 24'h0);
        tbl[4]  = mk(7'b0010000, 7'b1000000, 24'h0);
        tbl[5]  = mk(7'b0000000, 7'b1010000, 24'h0);
        tbl[6]  = mk(7'b0000101, 7'b1000000, 24'h0);
        tbl[7]  = mk(7'b0001000, 7'b1000000, 24'h0);
        tbl[8]  = mk(7'b0000000, 7'b1001000, 24'h0);
        tbl[9]  = mk(7'b1000000, 7'b1000000, 24'h0);
        tbl[10] = mk(7'b0000100, 7'b1000000, 24'h0);
        tbl[11] = mk(7'b0000001, 7'b1000100, 24'h0);
        tbl[12] = mk(7'b0000010, 7'b1000000, 24'h0);
        tbl[13] = mk(7'b0000000, 7'b1000000, 24'h0);
        tbl[14] = mk(7'b1100000, 7'b1000000, 24'h1);
        tbl[15] = mk(7'b0000000, 7'b0000000, 24'h1);
        tbl[16] = mk(7'b1000000, 7'b0000000, 24'h1);
        tbl[17] = mk(7'b0000000, 7'b1100000, 24'h0);
        tbl[18] = mk(7'b0110000, 7'b1000000, 24'h0);
        tbl[19] = mk(7'b0000000, 7'b0000000, 24'h0);
        tbl[20] = mk(7'b0000011, 7'b0000000, 24'h0);

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_outs", 64'({busy, init_start, shfl_start, deco_start, chk_start, found, not_found, mem_wren}), 64'd0);
        chk("reset_key", 64'(key), 64'd0);
        chk("reset_key_x", 64'(x_key), 64'(XS));
        @(posedge clk);
        #3 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            tick();
            {go, abort, init_done, shfl_done, deco_done, chk_done, chk_pass} = tbl[i].ins;
            #1;
            outs = {busy, init_start, shfl_start, deco_start, chk_start, found, not_found};
            checks++;
            if (outs !== tbl[i].outs || key !== tbl[i].key) begin
                errors++;
                $display("FAIL row%0d: got outs=%b key=0x%0h expected outs=%b key=0x%0h",
                         i, outs, key, tbl[i].outs, tbl[i].key);
            end
        end

        run_search(1'b0, 0, 1'b1, ended);
        chk("s1_status", 64'({found, not_found, busy}), 64'd4);
        chk("s1_key", 64'(key), 64'd0);
        chk("s1_init_starts", 64'(n_i), 64'd1);
        chk("s1_shfl_starts", 64'(n_s), 64'd1);
        chk("s1_deco_starts", 64'(n_d), 64'd1);
        chk("s1_chk_starts", 64'(n_c), 64'd1);

        run_search(1'b0, 2, 1'b0, ended);
        chk("s2_status", 64'({found, not_found, busy}), 64'd4);
        chk("s2_key", 64'(key), 64'd2);
        chk("s2_init_starts", 64'(n_i), 64'd3);
        chk("s2_chk_starts", 64'(n_c), 64'd3);

        run_search(1'b1, 99, 1'b0, ended);
        chk("s3_status", 64'({x_found, x_not_found, x_busy}), 64'd2);
        chk("s3_key", 64'(x_key), 64'(XM));
        chk("s3_attempts", 64'(n_i), 64'd3);

        sel_x = 1'b0;
        abort_test();
        reset_test();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc4_phase_sequencer.md
RC4_PHASE_SEQUENCER -- requirements
Module: rc4_phase_sequencer

Parameters
REQ-001 The block SHALL have parameter KEY_START, default 24'h000000: the first key tried after go.
REQ-002 The block SHALL have parameter KEY_MAX, default 24'h3FFFFF: the last key tried before the search is declared exhausted.

Interface
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have the port go, input, 1 bit: one-cycle pulse that starts a key search.
REQ-006 The block SHALL have the port abort, input, 1 bit: one-cycle pulse that cancels a search.
REQ-007 The block SHALL have the ports init_start, shfl_start, deco_start, chk_start, outputs, 1 bit each: one-cycle start pulses to the init, shuffle, decrypt and check engines.
REQ-008 The block SHALL have the ports init_done, shfl_done, deco_done, chk_done, inputs, 1 bit each: one-cycle completion pulses from those engines.
REQ-009 The block SHALL have the port chk_pass, input, 1 bit: check verdict, valid only in the cycle chk_done is high.
REQ-010 The block SHALL have the ports init_addr/init_data, shfl_addr/shfl_data, deco_addr/deco_data, inputs, 8 bits each, and init_wren, shfl_wren, deco_wren, inputs, 1 bit each: the S-memory requests from the three engines.
REQ-011 The block SHALL have the ports mem_addr and mem_data, outputs, 8 bits each, and mem_wren, output, 1 bit: the granted S-memory port.
REQ-012 The block SHALL have the port key, output, 24 bits: the current attempted key.
REQ-013 The block SHALL have the ports busy, found, not_found, outputs, 1 bit each: search status.

Function
REQ-014 The block SHALL implement the states IDLE, INIT, SHFL, DECO, CHECK, NEXT, FOUND and EXHAUST.
REQ-015 On go in IDLE, FOUND or EXHAUST, the block SHALL load key=KEY_START, clear found and not_found, and enter INIT on the next edge.
REQ-016 go in any other state SHALL be ignored.
REQ-017 On entry to INIT, SHFL, DECO or CHECK, the block SHALL assert the matching *_start for exactly the first cycle in that state.
REQ-018 The state transitions SHALL be: INIT -> SHFL on init_done; SHFL -> DECO on shfl_done; DECO -> CHECK on deco_done.
REQ-019 In CHECK, chk_done with chk_pass=1 SHALL go to FOUND and set found=1, holding key.
REQ-020 In CHECK, chk_done with chk_pass=0 SHALL go to EXHAUST with not_found=1 if key==KEY_MAX, otherwise to NEXT.
REQ-021 NEXT SHALL increment key by 1 (24-bit, no wrap reachable) and go to INIT after exactly 1 cycle.
REQ-022 done pulses from engines not owned by the current state SHALL be ignored; chk_pass SHALL be ignored without chk_done.
REQ-023 The S-memory mux SHALL be combinational from the registered state: INIT grants init_*, SHFL grants shfl_*, DECO grants deco_*.
REQ-024 In all other states, the S-memory mux SHALL drive mem_addr=0, mem_data=0, mem_wren=0.
REQ-025 busy SHALL be 1 in INIT, SHFL, DECO, CHECK and NEXT, and 0 elsewhere.
REQ-026 abort in any state SHALL enter IDLE on the next edge, keep key, and clear found and not_found.
REQ-027 Combinationally in the abort cycle, abort SHALL force mem_wren=0 and all *_start=0.
REQ-028 If abort and go arrive in the same cycle, abort SHALL win.
REQ-029 If a done pulse and abort arrive in the same cycle, abort SHALL win.
REQ-030 Latency: go at edge n SHALL give state INIT and init_start=1 in cycle n+1.
REQ-031 Latency: chk_done fail at edge m SHALL give NEXT in m+1, then INIT with init_start=1 and key+1 in m+2.

Reset
REQ-032 When rst_n=0, the block SHALL asynchronously force state=IDLE, key=KEY_START, found=0, not_found=0, busy=0, all *_start=0 and mem_wren=0.
REQ-033 The block SHALL hold the values of REQ-032 while rst_n is low, and leave IDLE only on a go received after rst_n is released.
REQ-034 Reset asserted mid-search SHALL abandon the search with no further start pulses issued.

Verification
REQ-035 Bench scenario, pass on first key: go; each engine returns done 5 cycles after its start; chk_pass=1 -> found=1, key=0, busy=0; exactly one pulse on each start.
REQ-036 Bench scenario, pass on the third key: chk_pass=0,0,1 -> key sequence 0,1,2; found=1 with key=2; 3 init_start pulses; NEXT lasts 1 cycle each time.
REQ-037 Bench scenario, exhaustion: KEY_START=24'h3FFFFD, KEY_MAX=24'h3FFFFF, always fail -> not_found=1, key=24'h3FFFFF, 3 attempts.
REQ-038 Bench scenario, mux isolation: in SHFL, drive init_wren=1 and deco_wren=1 with shfl_wren=0 -> mem_wren=0; mem_addr==shfl_addr every cycle.
REQ-039 Bench scenario, stray and simultaneous events: pulse deco_done during SHFL -> no state change; abort together with shfl_done -> IDLE, mem_wren=0 that cycle.
REQ-040 Bench scenario, reset: rst_n low mid-DECO, asynchronous to clk -> outputs reach reset values before the next edge; no start pulses until a new go.
